// File: rtl/hud_frame_compositor.sv
`default_nettype none
// ============================================================================
//  Module      : hud_frame_compositor
//  Description : Merges the HUD/sprite layer pixels over a background colour
//                by fixed priority, applies the frame-timed game-state effect
//                (death flash, death greyscale, finish fade), realigns
//                h_sync/v_sync/DE with the colour data and drives the video
//                output encoder. The pipeline is two registered stages.
//  Option      : COMPOSITOR_SCANLINE_EN - when defined, odd rows are halved
//                in brightness after the state effect (CRT scanline look).
//  Revision    : 1.0 - initial release
// ============================================================================
module hud_frame_compositor #(
    parameter int          NUM_LAYERS    = 4,
    parameter logic [23:0] BG_RGB        = 24'h87CEEB,
    parameter int          FLASH_FRAMES  = 8,
    parameter int          FLASH_TOGGLES = 6
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [15:0]              i_x,
    input  logic [15:0]              i_y,
    input  logic                     i_h_sync,
    input  logic                     i_v_sync,
    input  logic                     i_de,
    input  logic [NUM_LAYERS-1:0]    i_layer_hit,
    input  logic [24*NUM_LAYERS-1:0] i_layer_rgb,
    input  logic                     i_is_dead,
    input  logic                     i_is_finished,
    output logic [7:0]               o_red,
    output logic [7:0]               o_green,
    output logic [7:0]               o_blue,
    output logic                     o_h_sync,
    output logic                     o_v_sync,
    output logic                     o_de,
    output logic [1:0]               o_state
);

    // Counter widths sized to hold the terminal count values.
    localparam int TICK_W = (FLASH_FRAMES  > 1) ? $clog2(FLASH_FRAMES  + 1) : 1;
    localparam int TOG_W  = (FLASH_TOGGLES > 1) ? $clog2(FLASH_TOGGLES + 1) : 1;
    localparam logic [TICK_W-1:0] C_TICK_LAST = TICK_W'(FLASH_FRAMES - 1);
    localparam logic [TOG_W-1:0]  C_TOG_LAST  = TOG_W'(FLASH_TOGGLES - 1);
    localparam logic [1:0]        C_FADE_MAX  = 2'd3;

    typedef enum logic [1:0] {
        ST_PLAY   = 2'd0,
        ST_FLASH  = 2'd1,
        ST_DEAD   = 2'd2,
        ST_FINISH = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // Frame tick detection
    // ------------------------------------------------------------------------
    logic vs_prev_q;
    logic armed_q;
    logic tick_w;

    // The armed flag suppresses a spurious tick in the first cycle after reset
    // when v_sync happens to be high already.
    assign tick_w = armed_q & i_v_sync & ~vs_prev_q;

    // Remember the previous v_sync level and arm tick detection after reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vs_prev_q <= 1'b0;
            armed_q   <= 1'b0;
        end else begin
            vs_prev_q <= i_v_sync;
            armed_q   <= 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Game-state FSM
    // ------------------------------------------------------------------------
    state_t            state_q, state_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic [TOG_W-1:0]  toggles_q, toggles_d;
    logic              phase_q, phase_d;
    logic [1:0]        fade_q, fade_d;

    // State and effect-counter registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_PLAY;
            tick_cnt_q <= '0;
            toggles_q  <= '0;
            phase_q    <= 1'b0;
            fade_q     <= 2'd0;
        end else begin
            state_q    <= state_d;
            tick_cnt_q <= tick_cnt_d;
            toggles_q  <= toggles_d;
            phase_q    <= phase_d;
            fade_q     <= fade_d;
        end
    end

    // Next-state logic: flags are only sampled in PLAY, so later states latch.
    always_comb begin
        state_d    = state_q;
        tick_cnt_d = tick_cnt_q;
        toggles_d  = toggles_q;
        phase_d    = phase_q;
        fade_d     = fade_q;
        case (state_q)
            ST_PLAY: begin
                if (i_is_finished) begin
                    state_d = ST_FINISH;
                end else if (i_is_dead) begin
                    state_d = ST_FLASH;
                end
            end
            ST_FLASH: begin
                if (tick_w) begin
                    if (tick_cnt_q == C_TICK_LAST) begin
                        tick_cnt_d = '0;
                        phase_d    = ~phase_q;
                        if (toggles_q == C_TOG_LAST) begin
                            state_d = ST_DEAD;
                        end else begin
                            toggles_d = toggles_q + 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            ST_FINISH: begin
                if (tick_w) begin
                    if (tick_cnt_q == C_TICK_LAST) begin
                        tick_cnt_d = '0;
                        if (fade_q != C_FADE_MAX) begin
                            fade_d = fade_q + 1'b1;
                        end
                    end else begin
                        tick_cnt_d = tick_cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                // DEAD is terminal until reset.
            end
        endcase
        // Every state entry starts the effect from a clean slate.
        if (state_d != state_q) begin
            tick_cnt_d = '0;
            toggles_d  = '0;
            phase_d    = 1'b0;
            fade_d     = 2'd0;
        end
    end

    assign o_state = state_q;

    // ------------------------------------------------------------------------
    // Stage 1: priority layer select
    // ------------------------------------------------------------------------
    logic [23:0] s1_rgb_d, s1_rgb_q;
    logic        s1_bg_d, s1_bg_q;
    logic        s1_hs_q, s1_vs_q, s1_de_q;

    // Walk from lowest to highest priority so layer 0 overwrites last; colour
    // of a layer is only read when its hit bit is set, so X on unused layers
    // never reaches the register.
    always_comb begin
        s1_rgb_d = BG_RGB;
        s1_bg_d  = 1'b1;
        for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
            if (i_layer_hit[k]) begin
                s1_rgb_d = i_layer_rgb[24*k +: 24];
                s1_bg_d  = 1'b0;
            end
        end
    end

`ifdef COMPOSITOR_SCANLINE_EN
    logic s1_odd_q;
    logic unused_coord;
    assign unused_coord = ^{i_x, i_y[15:1]};

    // Carry the row parity alongside the stage-1 pixel.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_odd_q <= 1'b0;
        end else begin
            s1_odd_q <= i_y[0];
        end
    end
`else
    logic unused_coord;
    assign unused_coord = ^{i_x, i_y};
`endif

    // Stage-1 pixel and timing registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_rgb_q <= 24'h000000;
            s1_bg_q  <= 1'b0;
            s1_hs_q  <= 1'b0;
            s1_vs_q  <= 1'b0;
            s1_de_q  <= 1'b0;
        end else begin
            s1_rgb_q <= s1_rgb_d;
            s1_bg_q  <= s1_bg_d;
            s1_hs_q  <= i_h_sync;
            s1_vs_q  <= i_v_sync;
            s1_de_q  <= i_de;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2: state effect and blanking
    // ------------------------------------------------------------------------
    logic [7:0]  s1_r_w, s1_g_w, s1_b_w;
    logic [9:0]  luma_sum_w;
    logic [7:0]  luma_w;
    logic [23:0] s2_rgb_d;

    assign s1_r_w     = s1_rgb_q[23:16];
    assign s1_g_w     = s1_rgb_q[15:8];
    assign s1_b_w     = s1_rgb_q[7:0];
    assign luma_sum_w = {2'b00, s1_r_w} + {1'b0, s1_g_w, 1'b0} + {2'b00, s1_b_w};
    assign luma_w     = luma_sum_w[9:2];

    // Apply the effect of the current state, then optional scanline, then
    // force black outside active video.
    always_comb begin
        s2_rgb_d = s1_rgb_q;
        case (state_q)
            ST_FLASH: begin
                if (phase_q) begin
                    s2_rgb_d = {8'hFF, s1_g_w >> 1, s1_b_w >> 1};
                end
            end
            ST_DEAD: begin
                s2_rgb_d = {luma_w, luma_w, luma_w};
            end
            ST_FINISH: begin
                if (s1_bg_q) begin
                    s2_rgb_d = {s1_r_w >> fade_q, s1_g_w >> fade_q, s1_b_w >> fade_q};
                end
            end
            default: begin
                // PLAY passes the composited pixel unchanged.
            end
        endcase
`ifdef COMPOSITOR_SCANLINE_EN
        if (s1_odd_q) begin
            s2_rgb_d = {s2_rgb_d[23:16] >> 1, s2_rgb_d[15:8] >> 1, s2_rgb_d[7:0] >> 1};
        end
`endif
        if (!s1_de_q) begin
            s2_rgb_d = 24'h000000;
        end
    end

    // Output registers: colour and timing leave together, two cycles late.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_red    <= 8'h00;
            o_green  <= 8'h00;
            o_blue   <= 8'h00;
            o_h_sync <= 1'b0;
            o_v_sync <= 1'b0;
            o_de     <= 1'b0;
        end else begin
            o_red    <= s2_rgb_d[23:16];
            o_green  <= s2_rgb_d[15:8];
            o_blue   <= s2_rgb_d[7:0];
            o_h_sync <= s1_hs_q;
            o_v_sync <= s1_vs_q;
            o_de     <= s1_de_q;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hud_frame_compositor.sv
`default_nettype none
// ============================================================================
//  Module      : tb_hud_frame_compositor
//  Description : Directed self-checking bench for hud_frame_compositor.
//                Scanline expectations follow COMPOSITOR_SCANLINE_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_hud_frame_compositor;

    logic        clk;
    logic        rst;
    logic [15:0] x;
    logic [15:0] y;
    logic        hs, vs, de;
    logic [3:0]  hit;
    logic [95:0] lrgb;
    logic        dead, fin;
    logic [7:0]  r, g, b;
    logic        ohs, ovs, ode;
    logic [1:0]  st;

    int checks   = 0;
    int failures = 0;

    hud_frame_compositor dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_x           (x),
        .i_y           (y),
        .i_h_sync      (hs),
        .i_v_sync      (vs),
        .i_de          (de),
        .i_layer_hit   (hit),
        .i_layer_rgb   (lrgb),
        .i_is_dead     (dead),
        .i_is_finished (fin),
        .o_red         (r),
        .o_green       (g),
        .o_blue        (b),
        .o_h_sync      (ohs),
        .o_v_sync      (ovs),
        .o_de          (ode),
        .o_state       (st)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // One v_sync pulse: exactly one frame tick.
    task automatic vticks(input int n);
        for (int i = 0; i < n; i++) begin
            vs = 1'b1;
            step();
            vs = 1'b0;
            step();
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst  = 1'b1;
        x    = 16'd0;
        y    = 16'd0;
        hs   = 1'b0;
        vs   = 1'b0;
        de   = 1'b1;
        hit  = 4'b0000;
        lrgb = '0;
        dead = 1'b0;
        fin  = 1'b0;

        // Reset state
        steps(2);
        check("rst_rgb",   {8'h00, r, g, b}, 32'h00000000);
        check("rst_state", {30'd0, st}, 32'd0);
        check("rst_de",    {31'd0, ode}, 32'd0);

        // PLAY background after two cycles
        rst = 1'b0;
        steps(2);
        check("bg_play",    {8'h00, r, g, b}, 32'h0087CEEB);
        check("de_play",    {31'd0, ode}, 32'd1);
        check("state_play", {30'd0, st}, 32'd0);

        // Sync/DE alignment: one-cycle pulse appears exactly two cycles later
        hs = 1'b1; vs = 1'b1; de = 1'b0;
        step();
        hs = 1'b0; vs = 1'b0; de = 1'b1;
        check("sync_lat1", {30'd0, ohs, ovs}, 32'd0);
        step();
        check("sync_lat2", {29'd0, ohs, ovs, ode}, 32'b110);
        check("blank_rgb", {8'h00, r, g, b}, 32'h00000000);
        step();
        check("sync_lat3", {29'd0, ohs, ovs, ode}, 32'b001);
        check("bg_after_blank", {8'h00, r, g, b}, 32'h0087CEEB);

        // Priority: layer 1 beats layer 2, X on non-hit layers ignored
        hit  = 4'b0110;
        lrgb = {24'hxxxxxx, 24'hFF0000, 24'h000000, 24'hxxxxxx};
        steps(2);
        check("prio_l1", {8'h00, r, g, b}, 32'h00000000);
        hit  = 4'b1000;
        lrgb = {24'h123456, 24'hxxxxxx, 24'hxxxxxx, 24'hxxxxxx};
        steps(2);
        check("prio_l3", {8'h00, r, g, b}, 32'h00123456);
        hit  = 4'b0000;
        lrgb = {96{1'bx}};
        steps(2);
        check("nohit_x", {8'h00, r, g, b}, 32'h0087CEEB);

        // Death flash: one-cycle dead pulse latches FLASH
        dead = 1'b1;
        step();
        dead = 1'b0;
        step();
        check("state_flash", {30'd0, st}, 32'd1);
        check("flash_ph0", {8'h00, r, g, b}, 32'h0087CEEB);
        vticks(7);
        steps(2);
        check("flash_7ticks", {8'h00, r, g, b}, 32'h0087CEEB);
        vticks(1);
        steps(2);
        check("flash_ph1", {8'h00, r, g, b}, 32'h00FF6775);
        vticks(39);
        check("flash_47ticks", {30'd0, st}, 32'd1);
        vticks(1);
        check("state_dead", {30'd0, st}, 32'd2);
        steps(2);
        // (135 + 2*206 + 235) >> 2 = 195
        check("dead_grey", {8'h00, r, g, b}, 32'h00C3C3C3);

        // Asynchronous reset in the middle of a flash
        rst = 1'b1;
        step();
        rst = 1'b0;
        dead = 1'b1;
        step();
        dead = 1'b0;
        vticks(8);
        steps(2);
        check("flash_again", {8'h00, r, g, b}, 32'h00FF6775);
        #3;
        rst = 1'b1;
        #1;
        check("async_rgb",   {8'h00, r, g, b}, 32'h00000000);
        check("async_state", {30'd0, st}, 32'd0);
        check("async_de",    {31'd0, ode}, 32'd0);
        step();
        de = 1'b0;
        step();
        rst = 1'b0;
        step();
        de = 1'b1;
        step();
        check("rel_lat1", {31'd0, ode}, 32'd0);
        step();
        check("rel_bg", {8'h00, r, g, b}, 32'h0087CEEB);
        check("rel_state", {30'd0, st}, 32'd0);

        // Finish wins over dead; fade steps every 8 ticks, saturating at 3
        dead = 1'b1;
        fin  = 1'b1;
        step();
        check("state_finish", {30'd0, st}, 32'd3);
        vticks(8);
        steps(2);
        check("fade1", {8'h00, r, g, b}, 32'h00436775);
        vticks(8);
        steps(2);
        check("fade2", {8'h00, r, g, b}, 32'h0021333A);
        vticks(8);
        steps(2);
        check("fade3", {8'h00, r, g, b}, 32'h0010191D);
        vticks(8);
        steps(2);
        check("fade_sat", {8'h00, r, g, b}, 32'h0010191D);
        hit  = 4'b0001;
        lrgb = {72'h0, 24'hFFFFFF};
        steps(2);
        check("fade_sprite", {8'h00, r, g, b}, 32'h00FFFFFF);
        hit  = 4'b0000;
        dead = 1'b0;
        fin  = 1'b0;

        // Scanline rows in PLAY
        rst = 1'b1;
        step();
        rst = 1'b0;
        y = 16'd5;
        steps(2);
`ifdef COMPOSITOR_SCANLINE_EN
        check("row5", {8'h00, r, g, b}, 32'h00436775);
`else
        check("row5", {8'h00, r, g, b}, 32'h0087CEEB);
`endif
        y = 16'd6;
        steps(2);
        check("row6", {8'h00, r, g, b}, 32'h0087CEEB);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
